// File: rtl/nco_wave.sv
// Multi-mode NCO: phase accumulator with a handshaked tuning word that is applied
// only at a phase wrap, hard sync, or while stopped, followed by a registered wave shaper.
module nco_wave #(
  parameter int unsigned     ACC_W      = 16,
  parameter int unsigned     OUT_W      = 8,
  parameter logic [ACC_W-1:0] TW_INIT    = ACC_W'(1) << (ACC_W - OUT_W),
  parameter logic [ACC_W-1:0] PHASE_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             next,
  input  logic [ACC_W-1:0] tw,
  input  logic             tw_valid,
  output logic             tw_ready,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] duty,
  input  logic             sync,
  output logic [OUT_W-1:0] wave,
  output logic             wrap
);

  localparam logic [1:0] MODE_SAW_UP   = 2'd0;
  localparam logic [1:0] MODE_SAW_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;
  localparam logic [1:0] MODE_SQUARE   = 2'd3;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] tw_active_q, tw_active_d;
  logic [ACC_W-1:0] pend_tw_q, pend_tw_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tw_ready_q, tw_ready_d;
  logic [OUT_W-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic             accept;
  logic             load;
  logic [OUT_W-1:0] p;
  logic [OUT_W:0]   q;

  // Phase step, tuning handshake and shaper; all decisions use the new phase value.
  always_comb begin
    acc_d       = acc_q;
    wrap_d      = 1'b0;
    tw_active_d = tw_active_q;
    pend_tw_d   = pend_tw_q;
    pend_vld_d  = pend_vld_q;
    tw_ready_d  = tw_ready_q;
    wave_d      = wave_q;

    sum = {1'b0, acc_q} + {1'b0, tw_active_q};
    if (sync) begin
      acc_d = PHASE_INIT;
    end else if (next) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end

    // A stopped oscillator (tw_active == 0) would never wrap, so it loads immediately.
    accept = tw_valid && tw_ready_q;
    load   = pend_vld_q && (wrap_d || sync || (tw_active_q == '0));
    if (load) begin
      tw_active_d = pend_tw_q;
    end
    if (accept) begin
      pend_tw_d = tw;
    end
    pend_vld_d = accept || (pend_vld_q && !load);
    tw_ready_d = !pend_vld_q && !accept;

    p = acc_d[ACC_W-1 -: OUT_W];
    q = acc_d[ACC_W-1 -: OUT_W+1];
    case (mode)
      MODE_SAW_UP:   wave_d = p;
      MODE_SAW_DOWN: wave_d = ~p;
      MODE_TRIANGLE: wave_d = q[OUT_W] ? ~q[OUT_W-1:0] : q[OUT_W-1:0];
      MODE_SQUARE:   wave_d = (p < duty) ? '1 : '0;
      default:       wave_d = p;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= PHASE_INIT;
      tw_active_q <= TW_INIT;
      pend_tw_q   <= '0;
      pend_vld_q  <= 1'b0;
      tw_ready_q  <= 1'b0;
      wave_q      <= '0;
      wrap_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tw_active_q <= tw_active_d;
      pend_tw_q   <= pend_tw_d;
      pend_vld_q  <= pend_vld_d;
      tw_ready_q  <= tw_ready_d;
      wave_q      <= wave_d;
      wrap_q      <= wrap_d;
    end
  end

  assign wave     = wave_q;
  assign wrap     = wrap_q;
  assign tw_ready = tw_ready_q;

endmodule

// File: tb/tb_nco_wave.sv
// Scoreboard bench for nco_wave (ACC_W=8, OUT_W=4): a phase-arithmetic reference model
// queues the expected wave/wrap/tw_ready per cycle; a monitor pops and compares them.
module tb_nco_wave;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned OUT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             next;
  logic [ACC_W-1:0] tw;
  logic             tw_valid;
  logic             tw_ready;
  logic [1:0]       mode;
  logic [OUT_W-1:0] duty;
  logic             sync;
  logic [OUT_W-1:0] wave;
  logic             wrap;

  nco_wave #(
    .ACC_W(ACC_W), .OUT_W(OUT_W), .TW_INIT(8'h10), .PHASE_INIT(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .next(next), .tw(tw), .tw_valid(tw_valid),
    .tw_ready(tw_ready), .mode(mode), .duty(duty), .sync(sync),
    .wave(wave), .wrap(wrap)
  );

  typedef struct packed {
    logic [3:0] wave;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state: phase as an integer 0..255.
  int         m_phase;
  int         m_tw;
  bit         m_pend;
  int         m_pend_tw;
  bit         m_rdy;
  bit         offer_on;
  logic [7:0] offer_tw;
  int         cur_mode;
  int         cur_duty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] shape(input int ph, input int md, input int dt);
    int t;
    case (md)
      0: return 4'(ph / 16);
      1: return 4'(15 - ph / 16);
      2: begin
        t = ph / 8;
        return 4'((t < 16) ? t : 31 - t);
      end
      default: return ((ph / 16) < dt) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic drive(input bit r, input bit nx, input bit sy, input int md, input int dt);
    exp_t e;
    bit   acc_ok;
    bit   ld;
    bit   wr;
    int   np;
    @(negedge clk);
    rst_n    = r;
    next     = nx;
    sync     = sy;
    mode     = 2'(md);
    duty     = 4'(dt);
    tw_valid = offer_on;
    tw       = offer_tw;
    if (!r) begin
      m_phase = 0;
      m_tw    = 16;
      m_pend  = 1'b0;
      m_rdy   = 1'b0;
      e       = '{wave: 4'h0, wrap: 1'b0, rdy: 1'b0};
    end else begin
      acc_ok = offer_on && m_rdy;
      wr     = 1'b0;
      if (sy) np = 0;
      else if (nx) begin
        np = m_phase + m_tw;
        wr = (np >= 256);
        np = np % 256;
      end else np = m_phase;
      ld = m_pend && (wr || sy || m_tw == 0);
      if (acc_ok) m_rdy = 1'b0;
      else if (!m_pend) m_rdy = 1'b1;
      if (ld) begin
        m_tw   = m_pend_tw;
        m_pend = 1'b0;
      end
      if (acc_ok) begin
        m_pend    = 1'b1;
        m_pend_tw = int'(offer_tw);
        offer_on  = 1'b0;
      end
      m_phase = np;
      e = '{wave: shape(np, md, dt), wrap: wr, rdy: m_rdy};
    end
    sb.push_back(e);
  endtask

  task automatic offer_and_run(input logic [7:0] w, input bit nx, input int md, input int dt);
    offer_on = 1'b1;
    offer_tw = w;
    for (int i = 0; i < 300 && offer_on; i++) drive(1'b1, nx, 1'b0, md, dt);
  endtask

  task automatic run(input int n, input bit nx, input int md, input int dt);
    for (int i = 0; i < n; i++) drive(1'b1, nx, 1'b0, md, dt);
  endtask

  // Monitor: outputs are registered every cycle, so one expectation per edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      n_checks++;
      if ({wave, wrap, tw_ready} === {got.wave, got.wrap, got.rdy}) n_pass++;
      else $display("FAIL cycle_check cyc=%0d wave=%h exp=%h wrap=%b exp=%b tw_ready=%b exp=%b",
                    cyc, wave, got.wave, wrap, got.wrap, tw_ready, got.rdy);
    end
  end

  initial begin
    rst_n = 1'b0; next = 1'b0; sync = 1'b0; tw_valid = 1'b0;
    tw = '0; mode = '0; duty = '0;
    offer_on = 1'b0; offer_tw = '0;
    m_phase = 0; m_tw = 16; m_pend = 1'b0; m_pend_tw = 0; m_rdy = 1'b0;

    // Reset, then saw-up at the reset tuning word.
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    run(40, 1'b1, 0, 0);
    run(20, 1'b1, 1, 0);

    // Triangle at tw=0x08 after a hard sync.
    offer_and_run(8'h08, 1'b1, 2, 0);
    run(20, 1'b1, 2, 0);
    drive(1'b1, 1'b0, 1'b1, 2, 0);
    run(70, 1'b1, 2, 0);

    // Square with duty 4, then duty 0.
    drive(1'b1, 1'b0, 1'b1, 3, 4);
    run(40, 1'b1, 3, 4);
    run(20, 1'b1, 3, 0);

    // Retune to 0x10, then mid-cycle request for 0x20 waits for the wrap.
    offer_and_run(8'h10, 1'b1, 0, 0);
    run(40, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    run(5, 1'b1, 0, 0);
    offer_and_run(8'h20, 1'b1, 0, 0);
    run(30, 1'b1, 0, 0);

    // Sync together with next while a word is pending.
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    run(5, 1'b1, 0, 0);
    offer_and_run(8'h30, 1'b1, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    run(12, 1'b1, 0, 0);

    // Stop the oscillator with tw=0, then retune while stopped.
    offer_and_run(8'h00, 1'b1, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 0, 0);
    run(6, 1'b1, 0, 0);
    offer_and_run(8'h40, 1'b1, 0, 0);
    run(12, 1'b1, 0, 0);

    // Reset mid-run with a pending word.
    offer_and_run(8'h70, 1'b1, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    run(40, 1'b1, 0, 0);

    // Randomised traffic.
    cur_mode = 0;
    cur_duty = 8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) cur_mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) cur_duty = int'($urandom_range(0, 15));
      if (!offer_on && $urandom_range(0, 9) == 0) begin
        offer_on = 1'b1;
        offer_tw = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      end
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0, cur_mode, cur_duty);
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d required=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
